mem_refill_arbiter: RTL and testbench

- Shares the single read-refill memory port between two cache controllers: the instruction cache (I) and the data cache (D).
- Each controller issues a line refill of BURST_LEN words, one per memory ack.
- The arbiter grants one controller at a time with round-robin priority and locks the grant for the whole burst.
- It sits between the two cacheController memory-side ports and the external memory.

---
 rtl/mem_refill_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_refill_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_refill_arbiter.sv
// Round-robin arbiter sharing one read-refill memory port between the I-cache and D-cache.
// A grant is held for a whole BURST_LEN-word burst, or until the owner drops its request.
module mem_refill_arbiter #(
    parameter int ADR_WIDTH  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_icc2arb,
    input  logic [ADR_WIDTH-1:0]  adr_icc2arb,
    output logic                  ack_arb2icc,
    output logic [DATA_WIDTH-1:0] dat_arb2icc,
    input  logic                  req_dcc2arb,
    input  logic [ADR_WIDTH-1:0]  adr_dcc2arb,
    output logic                  ack_arb2dcc,
    output logic [DATA_WIDTH-1:0] dat_arb2dcc,
    output logic                  req_arb2mem,
    output logic [ADR_WIDTH-1:0]  adr_arb2mem,
    input  logic                  ack_mem2arb,
    input  logic [DATA_WIDTH-1:0] dat_mem2arb,
    output logic                  gnt_i,
    output logic                  gnt_d
);

    localparam int              BW        = $clog2(BURST_LEN + 1);
    localparam logic [BW-1:0]   LAST_BEAT = BW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            owner_req_s;

    assign owner_req_s = owner_q ? req_dcc2arb : req_icc2arb;

    // Next-state logic: arbitration in IDLE, beat counting in BUSY, release wait in DONE
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (req_icc2arb && req_dcc2arb) begin
                    owner_d = ~last_q;
                    state_d = ST_BUSY;
                    beat_d  = '0;
                end else if (req_icc2arb) begin
                    owner_d = 1'b0;
                    state_d = ST_BUSY;
                    beat_d  = '0;
                end else if (req_dcc2arb) begin
                    owner_d = 1'b1;
                    state_d = ST_BUSY;
                    beat_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // An owner dropping req wins over a coincident final ack
                if (!owner_req_s) begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                    beat_d  = '0;
                end else if (ack_mem2arb) begin
                    beat_d = beat_q + BW'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                        last_d  = owner_q;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (!owner_req_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // State registers; I wins the first tie because last resets to D
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    // Memory-side and cache-side steering, all derived from the registered owner
    always_comb begin
        req_arb2mem = 1'b0;
        adr_arb2mem = '0;
        ack_arb2icc = 1'b0;
        ack_arb2dcc = 1'b0;
        dat_arb2icc = '0;
        dat_arb2dcc = '0;
        if (state_q == ST_BUSY) begin
            req_arb2mem = owner_req_s;
            adr_arb2mem = owner_q ? adr_dcc2arb : adr_icc2arb;
            ack_arb2icc = ack_mem2arb & ~owner_q;
            ack_arb2dcc = ack_mem2arb & owner_q;
            dat_arb2icc = dat_mem2arb;
            dat_arb2dcc = dat_mem2arb;
        end else begin
            req_arb2mem = 1'b0;
        end
    end

    assign gnt_i = (state_q != ST_IDLE) && !owner_q;
    assign gnt_d = (state_q != ST_IDLE) && owner_q;

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Self-checking bench for mem_refill_arbiter: a cycle vector table fed through a scoreboard
// queue, plus hand-written round-robin and mid-burst reset sequences.
module tb_mem_refill_arbiter;

    localparam logic [31:0] ADR_I = 32'hFF07_BD08;
    localparam logic [31:0] ADR_D = 32'h1234_5670;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_i = 1'b0, req_d = 1'b0, ack_mem = 1'b0;
    logic [31:0] adr_i = ADR_I, adr_d = ADR_D, dat_mem = 32'h0;
    logic        ack_i, ack_d, req_mem, gnt_i, gnt_d;
    logic [31:0] dat_i, dat_d, adr_mem;

    int n_pass  = 0;
    int n_total = 0;

    mem_refill_arbiter #(.ADR_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(4)) dut (
        .clk(clk), .rst(rst),
        .req_icc2arb(req_i), .adr_icc2arb(adr_i), .ack_arb2icc(ack_i), .dat_arb2icc(dat_i),
        .req_dcc2arb(req_d), .adr_dcc2arb(adr_d), .ack_arb2dcc(ack_d), .dat_arb2dcc(dat_d),
        .req_arb2mem(req_mem), .adr_arb2mem(adr_mem),
        .ack_mem2arb(ack_mem), .dat_mem2arb(dat_mem),
        .gnt_i(gnt_i), .gnt_d(gnt_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ri, rd, ack;
        logic [31:0] dat;
        logic        e_req;
        logic [1:0]  e_adr;   // 0: zero, 1: I address, 2: D address
        logic        e_ai, e_ad, e_gi, e_gd, e_dat;
    } vec_t;

    vec_t vecs[29];
    vec_t sb_q[$];

    function automatic vec_t mv(input logic ri, rd, ack, input logic [31:0] dat,
                                input logic e_req, input logic [1:0] e_adr,
                                input logic ai, ad, gi, gd, edat);
        vec_t v;
        v.ri = ri; v.rd = rd; v.ack = ack; v.dat = dat;
        v.e_req = e_req; v.e_adr = e_adr;
        v.e_ai = ai; v.e_ad = ad; v.e_gi = gi; v.e_gd = gd; v.e_dat = edat;
        return v;
    endfunction

    function automatic logic [100:0] outs();
        return {req_mem, adr_mem, ack_i, ack_d, gnt_i, gnt_d, dat_i, dat_d};
    endfunction

    function automatic logic [100:0] expect_of(input vec_t v);
        logic [31:0] a;
        logic [31:0] dd;
        a  = (v.e_adr == 2'd1) ? ADR_I : ((v.e_adr == 2'd2) ? ADR_D : 32'h0);
        dd = v.e_dat ? v.dat : 32'h0;
        return {v.e_req, a, v.e_ai, v.e_ad, v.e_gi, v.e_gd, dd, dd};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_i = 1'b0; req_d = 1'b0; ack_mem = 1'b0; dat_mem = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_grant();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (gnt_i || gnt_d) begin
                got = 1'b1;
                break;
            end
        end
        chk("grant_seen", {127'd0, got}, {127'd0, 1'b1});
    endtask

    task automatic ack_beat(input logic own_d, input logic [31:0] d);
        @(posedge clk); #1;
        ack_mem = 1'b1; dat_mem = d;
        @(negedge clk);
        chk("owner_ack", {127'd0, own_d ? ack_d : ack_i}, {127'd0, 1'b1});
        chk("other_ack", {127'd0, own_d ? ack_i : ack_d}, {127'd0, 1'b0});
    endtask

    initial begin
        // ri rd ack dat            | req adr ai ad gi gd dat
        vecs[0]  = mv(1, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mv(1, 0, 1, 32'hFFFF_FFFF,  1, 1, 1, 0, 1, 0, 1);
        vecs[2]  = mv(1, 0, 1, 32'hFFFF_FFFF,  1, 1, 1, 0, 1, 0, 1);
        vecs[3]  = mv(1, 0, 0, 32'hFFFF_FFFF,  1, 1, 0, 0, 1, 0, 1);
        vecs[4]  = mv(1, 0, 1, 32'hFFFF_FFFF,  1, 1, 1, 0, 1, 0, 1);
        vecs[5]  = mv(1, 0, 1, 32'hFFFF_FFFF,  1, 1, 1, 0, 1, 0, 1);
        vecs[6]  = mv(1, 0, 1, 32'hFFFF_FFFF,  0, 0, 0, 0, 1, 0, 0);
        vecs[7]  = mv(0, 0, 0, 32'hFFFF_FFFF,  0, 0, 0, 0, 1, 0, 0);
        vecs[8]  = mv(0, 0, 1, 32'h0000_00A5,  0, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mv(1, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0);
        vecs[10] = mv(1, 0, 1, 32'h0000_00D1,  1, 1, 1, 0, 1, 0, 1);
        vecs[11] = mv(1, 1, 1, 32'h0000_00D2,  1, 1, 1, 0, 1, 0, 1);
        vecs[12] = mv(1, 1, 1, 32'h0000_00D3,  1, 1, 1, 0, 1, 0, 1);
        vecs[13] = mv(1, 1, 1, 32'h0000_00D4,  1, 1, 1, 0, 1, 0, 1);
        vecs[14] = mv(0, 1, 0, 32'h0,          0, 0, 0, 0, 1, 0, 0);
        vecs[15] = mv(0, 1, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0);
        vecs[16] = mv(0, 1, 1, 32'h0000_00E1,  1, 2, 0, 1, 0, 1, 1);
        vecs[17] = mv(1, 1, 1, 32'h0000_00E2,  1, 2, 0, 1, 0, 1, 1);
        vecs[18] = mv(1, 0, 0, 32'h0000_00E3,  0, 2, 0, 0, 0, 1, 1);
        vecs[19] = mv(1, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0);
        vecs[20] = mv(1, 1, 1, 32'h0000_0011,  1, 1, 1, 0, 1, 0, 1);
        vecs[21] = mv(1, 1, 1, 32'h0000_0012,  1, 1, 1, 0, 1, 0, 1);
        vecs[22] = mv(0, 1, 0, 32'h0000_0013,  0, 1, 0, 0, 1, 0, 1);
        vecs[23] = mv(0, 1, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0);
        vecs[24] = mv(0, 1, 1, 32'h0000_0021,  1, 2, 0, 1, 0, 1, 1);
        vecs[25] = mv(0, 1, 1, 32'h0000_0022,  1, 2, 0, 1, 0, 1, 1);
        vecs[26] = mv(0, 1, 1, 32'h0000_0023,  1, 2, 0, 1, 0, 1, 1);
        vecs[27] = mv(0, 0, 1, 32'h0000_0024,  0, 2, 0, 1, 0, 1, 1);
        vecs[28] = mv(0, 0, 1, 32'h0000_0025,  0, 0, 0, 0, 0, 0, 0);

        // Outputs held at zero while reset is asserted, whatever the inputs do
        rst = 1'b0;
        req_i = 1'b1; req_d = 1'b1; ack_mem = 1'b1; dat_mem = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {27'd0, outs()}, 128'd0);
        do_reset();

        // Vector table: single I refill, DONE hold, stray acks, held-off D, aborts
        for (int k = 0; k < 29; k++) begin
            @(posedge clk); #1;
            req_i = vecs[k].ri; req_d = vecs[k].rd;
            ack_mem = vecs[k].ack; dat_mem = vecs[k].dat;
            sb_q.push_back(vecs[k]);
            @(negedge clk);
            if (sb_q.size() == 0) begin
                chk("sb_empty", 128'd1, 128'd0);
            end else begin
                vec_t v;
                v = sb_q.pop_front();
                chk($sformatf("vec%0d", k), {27'd0, outs()}, {27'd0, expect_of(v)});
            end
        end

        // Round-robin from a tie right after reset: I, D, I, D
        do_reset();
        @(posedge clk); #1;
        req_i = 1'b1; req_d = 1'b1;
        for (int b = 0; b < 4; b++) begin
            logic own;
            own = b[0];
            wait_grant();
            chk("rr_owner", {126'd0, gnt_i, gnt_d}, {126'd0, ~own, own});
            chk("rr_adr", {96'd0, adr_mem}, {96'd0, own ? ADR_D : ADR_I});
            chk("rr_req", {127'd0, req_mem}, {127'd0, 1'b1});
            for (int w = 0; w < 4; w++) ack_beat(own, 32'hC0DE_0000 + 32'(w));
            @(posedge clk); #1;
            ack_mem = 1'b0;
            if (own) req_d = 1'b0; else req_i = 1'b0;
            @(negedge clk);
            chk("rr_done_req", {126'd0, req_mem, own ? gnt_d : gnt_i}, {126'd0, 1'b0, 1'b1});
            @(posedge clk); #1;
            if (own) req_d = 1'b1; else req_i = 1'b1;
        end

        // Reset during D's third beat, then a fresh I burst needs all four acks
        do_reset();
        @(posedge clk); #1;
        req_d = 1'b1;
        wait_grant();
        chk("rst_d_gnt", {126'd0, gnt_i, gnt_d}, {126'd0, 1'b0, 1'b1});
        ack_beat(1'b1, 32'h0000_0D01);
        ack_beat(1'b1, 32'h0000_0D02);
        @(posedge clk); #1;
        ack_mem = 1'b1; dat_mem = 32'h0000_0D03;
        #2 rst = 1'b0;
        #1 chk("async_reset_outputs", {27'd0, outs()}, 128'd0);
        @(negedge clk);
        req_d = 1'b0; ack_mem = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        req_i = 1'b1;
        wait_grant();
        chk("post_rst_gnt", {126'd0, gnt_i, gnt_d}, {126'd0, 1'b1, 1'b0});
        for (int w = 0; w < 3; w++) ack_beat(1'b0, 32'h0000_0A00 + 32'(w));
        @(posedge clk); #1;
        ack_mem = 1'b0;
        @(negedge clk);
        chk("post_rst_still_busy", {126'd0, req_mem, gnt_i}, {126'd0, 1'b1, 1'b1});
        ack_beat(1'b0, 32'h0000_0A03);
        @(posedge clk); #1;
        ack_mem = 1'b0;
        @(negedge clk);
        chk("post_rst_done", {126'd0, req_mem, gnt_i}, {126'd0, 1'b0, 1'b1});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
